// File: rtl/cmd_master_mux.sv
// Single-host command-bus master: decodes the upper address bits into one of
// NUM_SLAVES command channels, with ack timeout, error response and error count.
module cmd_master_mux #(
  parameter int HOST_ADDR_BITS         = 32,
  parameter int HOST_ADDR_BITS_FOR_SEL = 2,
  parameter int HOST_DATA_BITS         = 32,
  parameter int NUM_SLAVES             = 3,
  parameter int TIMEOUT_CYCLES         = 64,
  parameter logic [HOST_DATA_BITS-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                                        i_sysclk,
  input  logic                                        i_srst,
  input  logic                                        i_host_sel,
  input  logic                                        i_host_rd_wr_n,
  input  logic [HOST_ADDR_BITS-1:0]                   i_host_byte_addr,
  input  logic [HOST_DATA_BITS-1:0]                   i_host_wdata,
  output logic                                        o_host_ack,
  output logic                                        o_host_err,
  output logic [HOST_DATA_BITS-1:0]                   o_host_rdata,
  output logic                                        o_host_busy,
  output logic [NUM_SLAVES-1:0]                       o_cmd_sel,
  output logic                                        o_cmd_rd_wr_n,
  output logic [HOST_ADDR_BITS-HOST_ADDR_BITS_FOR_SEL-1:0] o_cmd_addr,
  output logic [HOST_DATA_BITS-1:0]                   o_cmd_wdata,
  input  logic [NUM_SLAVES-1:0]                       i_cmd_ack,
  input  logic [NUM_SLAVES*HOST_DATA_BITS-1:0]        i_cmd_rdata,
  output logic [15:0]                                 o_err_count
);

  localparam int SW = HOST_ADDR_BITS_FOR_SEL;
  localparam int AW = HOST_ADDR_BITS - HOST_ADDR_BITS_FOR_SEL;
  localparam int DW = HOST_DATA_BITS;
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [SW:0]   NUM_SEL  = (SW+1)'(NUM_SLAVES);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t          state, state_n;
  logic            pending, pending_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            host_ack_n, host_err_n, host_busy_n, cmd_rd_wr_n_n;
  logic [DW-1:0]   host_rdata_n, cmd_wdata_n;
  logic [NUM_SLAVES-1:0] cmd_sel_n;
  logic [AW-1:0]   cmd_addr_n;
  logic [15:0]     err_count_n;

  logic [SW-1:0]   idx_in;
  logic            mapped;
  logic [NUM_SLAVES-1:0] onehot;
  logic            ack_hit;
  logic [DW-1:0]   sel_rdata;
  logic [15:0]     err_count_inc;

  // Decode of the incoming request and of the currently selected channel
  always_comb begin
    idx_in    = i_host_byte_addr[HOST_ADDR_BITS-1 -: SW];
    mapped    = ({1'b0, idx_in} < NUM_SEL);
    onehot    = '0;
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      onehot[k] = (idx_in == SW'(k));
      if (o_cmd_sel[k]) sel_rdata = i_cmd_rdata[k*DW +: DW];
    end
    ack_hit       = |(i_cmd_ack & o_cmd_sel);
    err_count_inc = (o_err_count == 16'hFFFF) ? o_err_count : o_err_count + 16'd1;
  end

  always_comb begin
    state_n        = state;
    pending_n      = pending;
    cnt_n          = cnt;
    host_ack_n     = 1'b0;
    host_err_n     = o_host_err;
    host_rdata_n   = o_host_rdata;
    host_busy_n    = o_host_busy;
    cmd_sel_n      = o_cmd_sel;
    cmd_rd_wr_n_n  = o_cmd_rd_wr_n;
    cmd_addr_n     = o_cmd_addr;
    cmd_wdata_n    = o_cmd_wdata;
    err_count_n    = o_err_count;
    case (state)
      IDLE: begin
        if (i_host_sel) begin
          host_busy_n   = 1'b1;
          cmd_rd_wr_n_n = i_host_rd_wr_n;
          cmd_addr_n    = i_host_byte_addr[AW-1:0];
          cmd_wdata_n   = i_host_wdata;
          cnt_n         = '0;
          if (mapped) begin
            cmd_sel_n = onehot;
            state_n   = ACCESS;
          end else begin
            // Unmapped accesses spend one extra RESP cycle so the ack lands
            // on the same cycle a zero-wait slave would produce it.
            pending_n = 1'b1;
            state_n   = RESP;
          end
        end
      end
      ACCESS: begin
        if (ack_hit) begin
          host_ack_n   = 1'b1;
          host_err_n   = 1'b0;
          host_rdata_n = o_cmd_rd_wr_n ? sel_rdata : '0;
          cmd_sel_n    = '0;
          state_n      = RESP;
        end else if (cnt == CNT_LAST) begin
          host_ack_n   = 1'b1;
          host_err_n   = 1'b1;
          host_rdata_n = ERR_DATA;
          err_count_n  = err_count_inc;
          cmd_sel_n    = '0;
          state_n      = RESP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RESP: begin
        if (pending) begin
          pending_n    = 1'b0;
          host_ack_n   = 1'b1;
          host_err_n   = 1'b1;
          host_rdata_n = ERR_DATA;
          err_count_n  = err_count_inc;
        end else begin
          host_busy_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_sysclk) begin
    if (i_srst) begin
      state         <= IDLE;
      pending       <= 1'b0;
      cnt           <= '0;
      o_host_ack    <= 1'b0;
      o_host_err    <= 1'b0;
      o_host_rdata  <= '0;
      o_host_busy   <= 1'b0;
      o_cmd_sel     <= '0;
      o_cmd_rd_wr_n <= 1'b1;
      o_cmd_addr    <= '0;
      o_cmd_wdata   <= '0;
      o_err_count   <= '0;
    end else begin
      state         <= state_n;
      pending       <= pending_n;
      cnt           <= cnt_n;
      o_host_ack    <= host_ack_n;
      o_host_err    <= host_err_n;
      o_host_rdata  <= host_rdata_n;
      o_host_busy   <= host_busy_n;
      o_cmd_sel     <= cmd_sel_n;
      o_cmd_rd_wr_n <= cmd_rd_wr_n_n;
      o_cmd_addr    <= cmd_addr_n;
      o_cmd_wdata   <= cmd_wdata_n;
      o_err_count   <= err_count_n;
    end
  end

endmodule

// File: tb/tb_cmd_master_mux.sv
// Directed, table-driven bench for cmd_master_mux with hand-written sequences
// for late acks and mid-access reset.
module tb_cmd_master_mux;

  logic        i_sysclk;
  logic        i_srst;
  logic        i_host_sel;
  logic        i_host_rd_wr_n;
  logic [31:0] i_host_byte_addr;
  logic [31:0] i_host_wdata;
  logic        o_host_ack;
  logic        o_host_err;
  logic [31:0] o_host_rdata;
  logic        o_host_busy;
  logic [2:0]  o_cmd_sel;
  logic        o_cmd_rd_wr_n;
  logic [29:0] o_cmd_addr;
  logic [31:0] o_cmd_wdata;
  logic [2:0]  i_cmd_ack;
  logic [95:0] i_cmd_rdata;
  logic [15:0] o_err_count;

  int errors = 0;
  int checks = 0;

  cmd_master_mux #(
    .HOST_ADDR_BITS(32), .HOST_ADDR_BITS_FOR_SEL(2), .HOST_DATA_BITS(32),
    .NUM_SLAVES(3), .TIMEOUT_CYCLES(64), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .i_sysclk(i_sysclk), .i_srst(i_srst), .i_host_sel(i_host_sel),
    .i_host_rd_wr_n(i_host_rd_wr_n), .i_host_byte_addr(i_host_byte_addr),
    .i_host_wdata(i_host_wdata), .o_host_ack(o_host_ack), .o_host_err(o_host_err),
    .o_host_rdata(o_host_rdata), .o_host_busy(o_host_busy), .o_cmd_sel(o_cmd_sel),
    .o_cmd_rd_wr_n(o_cmd_rd_wr_n), .o_cmd_addr(o_cmd_addr), .o_cmd_wdata(o_cmd_wdata),
    .i_cmd_ack(i_cmd_ack), .i_cmd_rdata(i_cmd_rdata), .o_err_count(o_err_count)
  );

  initial i_sysclk = 1'b0;
  always #5 i_sysclk = ~i_sysclk;

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          wait_cyc;
    int          ack_ch;
    logic [31:0] srd;
    int          noise_cyc;
    int          exp_ack_cyc;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [2:0]  exp_sel;
    int          exp_sel_cyc;
    logic [29:0] exp_cmd_addr;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_output_reset(input string tag);
    check({tag, " ack"},       64'(o_host_ack), 64'd0);
    check({tag, " err"},       64'(o_host_err), 64'd0);
    check({tag, " rdata"},     64'(o_host_rdata), 64'd0);
    check({tag, " busy"},      64'(o_host_busy), 64'd0);
    check({tag, " cmd_sel"},   64'(o_cmd_sel), 64'd0);
    check({tag, " rd_wr_n"},   64'(o_cmd_rd_wr_n), 64'd1);
    check({tag, " cmd_addr"},  64'(o_cmd_addr), 64'd0);
    check({tag, " cmd_wdata"}, 64'(o_cmd_wdata), 64'd0);
    check({tag, " err_count"}, 64'(o_err_count), 64'd0);
  endtask

  // Entered and left just after a rising edge; cycle 0 is the strobe cycle.
  task automatic apply_stimulus(input vec_t v, input string tag);
    int ack_cyc = -1;
    int sel_cyc = 0;
    logic seen = 1'b0;
    logic unstable = 1'b0;
    logic busy_bad = 1'b0;
    logic [2:0]  snap_sel = '0;
    logic        snap_rw = 1'b0;
    logic [29:0] snap_addr = '0;
    logic [31:0] snap_wdata = '0;
    logic        got_err = 1'b0;
    logic [31:0] got_rdata = '0;
    i_cmd_rdata = {3{32'hBAD0_0000}};
    i_cmd_rdata[v.ack_ch*32 +: 32] = v.srd;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (cyc == 0) begin
        i_host_sel = 1'b1; i_host_rd_wr_n = v.rd;
        i_host_byte_addr = v.addr; i_host_wdata = v.wdata;
      end else if (cyc == v.noise_cyc) begin
        i_host_sel = 1'b1; i_host_rd_wr_n = 1'b0;
        i_host_byte_addr = 32'h0000_0000; i_host_wdata = 32'h5555_0000;
      end else begin
        i_host_sel = 1'b0;
      end
      i_cmd_ack = '0;
      if (v.wait_cyc >= 0 && cyc == 1 + v.wait_cyc) i_cmd_ack[v.ack_ch] = 1'b1;
      if (cyc == v.noise_cyc) i_cmd_ack[0] = 1'b1;
      @(negedge i_sysclk);
      if (o_host_busy !== (cyc != 0)) busy_bad = 1'b1;
      if (o_cmd_sel != '0) begin
        sel_cyc++;
        if (!seen) begin
          seen = 1'b1; snap_sel = o_cmd_sel; snap_rw = o_cmd_rd_wr_n;
          snap_addr = o_cmd_addr; snap_wdata = o_cmd_wdata;
        end else if ({snap_sel, snap_rw, snap_addr, snap_wdata} !==
                     {o_cmd_sel, o_cmd_rd_wr_n, o_cmd_addr, o_cmd_wdata}) begin
          unstable = 1'b1;
        end
      end
      if (o_host_ack === 1'b1) begin
        ack_cyc = cyc; got_err = o_host_err; got_rdata = o_host_rdata;
      end
      @(posedge i_sysclk); #1;
      if (ack_cyc >= 0) break;
    end
    i_host_sel = 1'b0;
    i_cmd_ack  = '0;
    check({tag, " ack_cycle"}, 64'(ack_cyc), 64'(v.exp_ack_cyc));
    check({tag, " host_err"}, 64'(got_err), 64'(v.exp_err));
    check({tag, " host_rdata"}, 64'(got_rdata), 64'(v.exp_rdata));
    check({tag, " cmd_sel"}, 64'(snap_sel), 64'(v.exp_sel));
    check({tag, " sel_cycles"}, 64'(sel_cyc), 64'(v.exp_sel_cyc));
    check({tag, " busy_window"}, 64'(busy_bad), 64'd0);
    if (v.exp_sel != '0) begin
      check({tag, " cmd_addr"}, 64'(snap_addr), 64'(v.exp_cmd_addr));
      check({tag, " cmd_rd_wr_n"}, 64'(snap_rw), 64'(v.rd));
      check({tag, " cmd_wdata"}, 64'(snap_wdata), 64'(v.wdata));
      check({tag, " stable"}, 64'(unstable), 64'd0);
    end
    @(negedge i_sysclk);
    check({tag, " busy_after"}, 64'(o_host_busy), 64'd0);
    check({tag, " err_count"}, 64'(o_err_count), 64'(v.exp_cnt));
    @(posedge i_sysclk); #1;
  endtask

  initial begin
    vec_t tv;
    //            rd    addr          wdata         wait ch srd           noise ack err rdata          sel     selc addr          cnt
    vecs[0] = '{1'b1, 32'h4000_0010, 32'h0,         3,  1, 32'h1234_5678, -1,  5, 1'b0, 32'h1234_5678, 3'b010, 4,  30'h0000_0010, 16'd0};
    vecs[1] = '{1'b0, 32'h0000_0024, 32'hA5A5_A5A5, 0,  0, 32'h7777_7777, -1,  2, 1'b0, 32'h0,         3'b001, 1,  30'h0000_0024, 16'd0};
    vecs[2] = '{1'b1, 32'hC000_0000, 32'h0,         -1, 0, 32'h0,         -1,  2, 1'b1, 32'hDEAD_BEEF, 3'b000, 0,  30'h0,         16'd1};
    vecs[3] = '{1'b1, 32'h8000_0ABC, 32'h0,         1,  2, 32'hCAFE_F00D, -1,  3, 1'b0, 32'hCAFE_F00D, 3'b100, 2,  30'h0000_0ABC, 16'd1};
    vecs[4] = '{1'b0, 32'hFFFF_FFFC, 32'h1,         -1, 0, 32'h0,         -1,  2, 1'b1, 32'hDEAD_BEEF, 3'b000, 0,  30'h0,         16'd2};
    vecs[5] = '{1'b1, 32'h0000_0100, 32'h0,         -1, 0, 32'h0,         -1, 65, 1'b1, 32'hDEAD_BEEF, 3'b001, 64, 30'h0000_0100, 16'd3};
    vecs[6] = '{1'b1, 32'h7FFF_FFF0, 32'h0,         63, 1, 32'h0BAD_C0DE, -1, 65, 1'b0, 32'h0BAD_C0DE, 3'b010, 64, 30'h3FFF_FFF0, 16'd3};
    vecs[7] = '{1'b0, 32'h8000_0004, 32'h1357_9BDF, 5,  2, 32'h2468_ACE0, -1,  7, 1'b0, 32'h0,         3'b100, 6,  30'h0000_0004, 16'd3};
    vecs[8] = '{1'b1, 32'h4000_0020, 32'h0,         4,  1, 32'h1111_2222, 2,   6, 1'b0, 32'h1111_2222, 3'b010, 5,  30'h0000_0020, 16'd3};

    i_srst = 1'b1; i_host_sel = 1'b0; i_host_rd_wr_n = 1'b0;
    i_host_byte_addr = '0; i_host_wdata = '0; i_cmd_ack = '0; i_cmd_rdata = '0;
    repeat (3) @(posedge i_sysclk);
    #1;
    @(negedge i_sysclk);
    check_output_reset("reset");
    @(posedge i_sysclk); #1;
    i_srst = 1'b0;
    @(posedge i_sysclk); #1;

    for (int i = 0; i < 9; i++) apply_stimulus(vecs[i], $sformatf("vec%0d", i));

    // Timeout on ch2, then the slave acks two cycles after the host ack.
    tv = '{1'b0, 32'h8000_0008, 32'h0F0F_0F0F, -1, 2, 32'h0, -1, 65, 1'b1, 32'hDEAD_BEEF, 3'b100, 64, 30'h0000_0008, 16'd4};
    apply_stimulus(tv, "timeout_ch2");
    for (int c = 0; c < 3; c++) begin
      i_cmd_ack = (c < 2) ? 3'b100 : 3'b000;
      i_cmd_rdata[64 +: 32] = 32'h9999_9999;
      @(negedge i_sysclk);
      check($sformatf("late_ack%0d ack", c), 64'(o_host_ack), 64'd0);
      check($sformatf("late_ack%0d busy", c), 64'(o_host_busy), 64'd0);
      check($sformatf("late_ack%0d sel", c), 64'(o_cmd_sel), 64'd0);
      @(posedge i_sysclk); #1;
    end
    i_cmd_ack = '0;
    check("late_ack err_count", 64'(o_err_count), 64'd4);

    // Reset asserted while a ch2 read waits in ACCESS.
    i_host_sel = 1'b1; i_host_rd_wr_n = 1'b1;
    i_host_byte_addr = 32'h8000_0040; i_host_wdata = 32'h3333_4444;
    @(posedge i_sysclk); #1;
    i_host_sel = 1'b0;
    @(posedge i_sysclk); #1;
    @(negedge i_sysclk);
    check("pre_reset cmd_sel", 64'(o_cmd_sel), 64'b100);
    @(posedge i_sysclk); #1;
    i_srst = 1'b1;
    @(posedge i_sysclk); #1;
    i_srst = 1'b0;
    @(negedge i_sysclk);
    check_output_reset("mid_reset");
    begin
      int acks = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge i_sysclk);
        if (o_host_ack === 1'b1) acks++;
      end
      check("mid_reset no_ack", 64'(acks), 64'd0);
    end
    @(posedge i_sysclk); #1;
    tv = '{1'b1, 32'h0000_0030, 32'h0, 2, 0, 32'h8765_4321, -1, 4, 1'b0, 32'h8765_4321, 3'b001, 3, 30'h0000_0030, 16'd0};
    apply_stimulus(tv, "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cmd_master_mux.md
# cmd_master_mux

Parametrised successor of the single-host command-bus master: accepts one host read/write at a time and decodes the upper byte-address bits into one of NUM_SLAVES command channels. It adds what the previous generation lacked: a configurable slave count, per-access ack timeout, error signalling for unmapped or timed-out accesses, and a saturating error counter. It sits between a host bridge (UART/SPI/Ethernet register path) and the register-file slaves inside a subsystem top.

## Interface

- HOST_ADDR_BITS, 32, host byte-address width
- HOST_ADDR_BITS_FOR_SEL, 2, MSBs of the byte address used as slave index
- HOST_DATA_BITS, 32, data width
- NUM_SLAVES, 3, populated channels; 1 ≤ NUM_SLAVES ≤ 2**HOST_ADDR_BITS_FOR_SEL
- TIMEOUT_CYCLES, 64, cycles to wait for slave ack; ≥ 2
- ERR_DATA, 32'hDEAD_BEEF, rdata returned on any error


- i_sysclk  in  1  clock
- i_srst  in  1  synchronous active-high reset
- i_host_sel  in  1  single-cycle request strobe
- i_host_rd_wr_n  in  1  1 = read, 0 = write
- i_host_byte_addr  in  HOST_ADDR_BITS  byte address
- i_host_wdata  in  HOST_DATA_BITS  write data
- o_host_ack  out  1  one-cycle completion pulse
- o_host_err  out  1  valid with o_host_ack; 1 = unmapped or timeout
- o_host_rdata  out  HOST_DATA_BITS  valid with o_host_ack (reads; ERR_DATA on error)
- o_host_busy  out  1  access in flight; i_host_sel ignored while high
- o_cmd_sel  out  NUM_SLAVES  one-hot channel select, level
- o_cmd_rd_wr_n  out  1  shared
- o_cmd_addr  out  HOST_ADDR_BITS-HOST_ADDR_BITS_FOR_SEL  byte address with select bits stripped
- o_cmd_wdata  out  HOST_DATA_BITS  shared
- i_cmd_ack  in  NUM_SLAVES  per-channel one-cycle ack
- i_cmd_rdata  in  NUM_SLAVES*HOST_DATA_BITS  channel k at bits [k*HOST_DATA_BITS +: HOST_DATA_BITS], valid with its ack
- o_err_count  out  16  saturating count of errored accesses

## Operation

- States: IDLE, ACCESS, RESP.
- IDLE: i_host_sel=1 registers rd_wr_n, addr (low bits), wdata and index = addr[MSB -: HOST_ADDR_BITS_FOR_SEL]; busy goes high.
  - index < NUM_SLAVES → ACCESS, o_cmd_sel[index]=1, timeout counter cleared.
  - index ≥ NUM_SLAVES → RESP with err=1, no channel selected.
- ACCESS: o_cmd_sel held, shared outputs stable. Counter increments each cycle.
  - i_cmd_ack[index]=1 → capture i_cmd_rdata slice (reads; writes return 0), err=0, drop sel, → RESP.
  - counter reaches TIMEOUT_CYCLES-1 with no ack → err=1, drop sel, → RESP. Ack arriving on that same cycle wins (no error).
  - Acks on non-selected channels ignored.
- RESP: one cycle, o_host_ack=1 with err/rdata; o_err_count += err (saturates at 16'hFFFF); → IDLE, busy low.
- Late ack from a timed-out slave, arriving in RESP or IDLE, is ignored.
- i_host_sel while busy=1: dropped, no queueing, no error count.

## Timing

- All outputs registered. Reset values: o_host_ack 0, o_host_err 0, o_host_rdata 0, o_host_busy 0, o_cmd_sel 0, o_cmd_rd_wr_n 1, o_cmd_addr 0, o_cmd_wdata 0, o_err_count 0; state IDLE.
- sel at cycle 0 → o_cmd_sel at cycle 1 → earliest slave ack cycle 1 → o_host_ack cycle 2. Latency = 2 + slave wait cycles.
- Unmapped: o_host_ack at cycle 2, o_cmd_sel never asserted.
- Timeout: o_cmd_sel high cycles 1..TIMEOUT_CYCLES, o_host_ack at TIMEOUT_CYCLES+1.
- o_host_busy high cycle 1 through the ack cycle; new sel accepted the cycle after ack (back-to-back rate: one access per 3 cycles minimum).
- i_srst mid-access: next cycle all outputs at reset values, in-flight access abandoned, no host ack.

## Test plan

- Read ch1 addr 32'h4000_0010, slave acks 3 cycles after sel with 32'h1234_5678 → o_cmd_addr 30'h0000_0010, o_host_ack cycle 5, rdata 32'h1234_5678, err 0.
- Write ch0 wdata 32'hA5A5_A5A5, slave acks immediately → o_cmd_rd_wr_n 0, ack cycle 2, err 0, o_err_count 0.
- Access index 3 with NUM_SLAVES=3 → no o_cmd_sel, ack cycle 2, err 1, rdata ERR_DATA, o_err_count 1.
- Slave never acks, TIMEOUT_CYCLES=64 → o_cmd_sel high 64 cycles, ack cycle 65, err 1; late ack 2 cycles later ignored.
- i_host_sel pulsed while busy plus ack from wrong channel → both ignored, original access completes normally.
- Assert i_srst in ACCESS → all outputs reset next cycle, no o_host_ack; subsequent read completes normally.
